// File: rtl/uart_pkg.sv
// Shared state types, register offsets and status bit positions for mmio_uart.
// UART_PARITY_EN adds an even-parity bit between DATA and STOP in both directions.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam logic [2:0] UART_DATA_OFS = 3'h0;
    localparam logic [2:0] UART_STAT_OFS = 3'h4;

    localparam int unsigned ST_RX_PRESENT = 32'd0;
    localparam int unsigned ST_TX_FULL    = 32'd1;
    localparam int unsigned ST_TX_IDLE    = 32'd2;
    localparam int unsigned ST_RX_OVERRUN = 32'd3;
    localparam int unsigned ST_FRAME_ERR  = 32'd4;
    localparam int unsigned ST_PARITY_ERR = 32'd5;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mmio_uart_if.sv
// Byte-wide MMIO link between the memory controller (master) and the UART (slave).
interface mmio_uart_if;
    logic       tx_wen;
    logic       rx_ren;
    logic [2:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       tx_full;
    logic       rx_data_present;

    modport master (output tx_wen, rx_ren, uart_addr, uart_din,
                    input  uart_dout, tx_full, rx_data_present);
    modport slave  (input  tx_wen, rx_ren, uart_addr, uart_din,
                    output uart_dout, tx_full, rx_data_present);
endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with extra-MSB pointers; a pop on a full FIFO lets a same-edge push in.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // pointer advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mmio_uart.sv
// MMIO UART: DATA/STATUS registers, TX/RX FIFOs and 8N1 serialiser/deserialiser.
// UART_PARITY_EN enables an even parity bit and the sticky parity_err status bit.
module mmio_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    mmio_uart_if.slave bus,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0] tx_head_s, rx_head_s, status_s;
    logic data_rd_s, stat_rd_s, rx_ferr_s;
    logic overrun_r, frame_err_r, uart_tx_r, rx_prev_r;
    logic [1:0] rx_sync_r;
    logic rx_line_s;

    tx_state_t     tx_state_r, tx_state_s;
    rx_state_t     rx_state_r, rx_state_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_s, rx_cnt_r, rx_cnt_s;
    logic [2:0]    tx_bit_r, tx_bit_s, rx_bit_r, rx_bit_s;
    logic [7:0]    tx_shift_r, tx_shift_s, rx_shift_r, rx_shift_s;
    logic          tx_line_s;
`ifdef UART_PARITY_EN
    logic tx_par_r, rx_perr_r, rx_perr_s, rx_perr_set_s, parity_err_r;
`endif

    assign tx_push_s = bus.tx_wen && (bus.uart_addr == UART_DATA_OFS);
    assign data_rd_s = bus.rx_ren && (bus.uart_addr == UART_DATA_OFS);
    assign stat_rd_s = bus.rx_ren && (bus.uart_addr == UART_STAT_OFS);
    assign rx_pop_s  = data_rd_s && !rx_empty_s;
    assign rx_line_s = rx_sync_r[1];

    uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push_s), .pop(tx_pop_s), .din(bus.uart_din),
        .head(tx_head_s), .full(tx_full_s), .empty(tx_empty_s));

    uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_s), .pop(rx_pop_s), .din(rx_shift_r),
        .head(rx_head_s), .full(rx_full_s), .empty(rx_empty_s));

    // status word assembly
    always_comb begin
        status_s                = 8'h00;
        status_s[ST_RX_PRESENT] = !rx_empty_s;
        status_s[ST_TX_FULL]    = tx_full_s;
        status_s[ST_TX_IDLE]    = tx_empty_s && (tx_state_r == TX_IDLE);
        status_s[ST_RX_OVERRUN] = overrun_r;
        status_s[ST_FRAME_ERR]  = frame_err_r;
`ifdef UART_PARITY_EN
        status_s[ST_PARITY_ERR] = parity_err_r;
`else
        status_s[ST_PARITY_ERR] = 1'b0;
`endif
    end

    // read mux: the controller samples this at the strobe edge
    always_comb begin
        bus.uart_dout = 8'h00;
        case (bus.uart_addr)
            UART_DATA_OFS: bus.uart_dout = rx_empty_s ? 8'h00 : rx_head_s;
            UART_STAT_OFS: bus.uart_dout = status_s;
            default:       bus.uart_dout = 8'h00;
        endcase
    end

    assign bus.tx_full         = tx_full_s;
    assign bus.rx_data_present = !rx_empty_s;
    assign uart_tx             = uart_tx_r;

    // TX next-state; the line level is registered one cycle behind the state
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + CW'(1);
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_pop_s   = 1'b0;
        tx_line_s  = 1'b1;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = '0;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_head_s;
                    tx_state_s = TX_START;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                tx_line_s = 1'b0;
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                    tx_state_s = TX_DATA;
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_DATA: begin
                tx_line_s = tx_shift_r[0];
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    tx_bit_s   = tx_bit_r + 3'd1;
`ifdef UART_PARITY_EN
                    tx_state_s = (tx_bit_r == 3'd7) ? TX_PARITY : TX_DATA;
`else
                    tx_state_s = (tx_bit_r == 3'd7) ? TX_STOP : TX_DATA;
`endif
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx_line_s = tx_par_r;
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_state_s = TX_STOP;
                end else begin
                    tx_state_s = TX_PARITY;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_r != BIT_LAST) begin
                    tx_state_s = TX_STOP;
                end else if (!tx_empty_s) begin
                    tx_cnt_s   = '0;
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_head_s;
                    tx_state_s = TX_START;
                end else begin
                    tx_cnt_s   = '0;
                    tx_state_s = TX_IDLE;
                end
            end
            default: begin
                tx_cnt_s   = '0;
                tx_state_s = TX_IDLE;
            end
        endcase
    end

    // RX next-state: falling edge, mid-start check, then centre sampling
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r + CW'(1);
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_push_s  = 1'b0;
        rx_ferr_s  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_s     = rx_perr_r;
        rx_perr_set_s = 1'b0;
`endif
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s   = '0;
                rx_state_s = (rx_prev_r && !rx_line_s) ? RX_START : RX_IDLE;
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s   = '0;
                    rx_bit_s   = 3'd0;
                    rx_state_s = rx_line_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_line_s, rx_shift_r[7:1]};
                    rx_bit_s   = rx_bit_r + 3'd1;
`ifdef UART_PARITY_EN
                    rx_state_s = (rx_bit_r == 3'd7) ? RX_PARITY : RX_DATA;
`else
                    rx_state_s = (rx_bit_r == 3'd7) ? RX_STOP : RX_DATA;
`endif
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_perr_s  = (rx_line_s != even_parity(rx_shift_r));
                    rx_state_s = RX_STOP;
                end else begin
                    rx_state_s = RX_PARITY;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_state_s = RX_IDLE;
                    if (!rx_line_s) rx_ferr_s = 1'b1;
`ifdef UART_PARITY_EN
                    else if (rx_perr_r) rx_perr_set_s = 1'b1;
`endif
                    else rx_push_s = 1'b1;
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            default: begin
                rx_cnt_s   = '0;
                rx_state_s = RX_IDLE;
            end
        endcase
    end

    // state, datapath and sticky-status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r  <= TX_IDLE;
            tx_cnt_r    <= '0;
            tx_bit_r    <= 3'd0;
            tx_shift_r  <= 8'h00;
            uart_tx_r   <= 1'b1;
            rx_state_r  <= RX_IDLE;
            rx_cnt_r    <= '0;
            rx_bit_r    <= 3'd0;
            rx_shift_r  <= 8'h00;
            rx_sync_r   <= 2'b11;
            rx_prev_r   <= 1'b1;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_r     <= 1'b0;
            rx_perr_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            tx_state_r  <= tx_state_s;
            tx_cnt_r    <= tx_cnt_s;
            tx_bit_r    <= tx_bit_s;
            tx_shift_r  <= tx_shift_s;
            uart_tx_r   <= tx_line_s;
            rx_state_r  <= rx_state_s;
            rx_cnt_r    <= rx_cnt_s;
            rx_bit_r    <= rx_bit_s;
            rx_shift_r  <= rx_shift_s;
            rx_sync_r   <= {rx_sync_r[0], uart_rx};
            rx_prev_r   <= rx_line_s;
            // a new event on the clearing edge wins so it is never lost
            overrun_r   <= (overrun_r && !stat_rd_s) || (rx_push_s && rx_full_s && !rx_pop_s);
            frame_err_r <= (frame_err_r && !stat_rd_s) || rx_ferr_s;
`ifdef UART_PARITY_EN
            tx_par_r     <= tx_pop_s ? even_parity(tx_head_s) : tx_par_r;
            rx_perr_r    <= rx_perr_s;
            parity_err_r <= (parity_err_r && !stat_rd_s) || rx_perr_set_s;
`endif
        end
    end
endmodule

// File: tb/tb_mmio_uart.sv
// Randomised self-checking bench for mmio_uart with a queue-based reference model.
module tb_mmio_uart;
    localparam int CPB = 4;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    mmio_uart_if bus_if ();

    mmio_uart #(.CLKS_PER_BIT(CPB), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .uart_tx(uart_tx), .uart_rx(uart_rx));

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // reference model state
    logic [7:0] m_rxq[$];
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_perr = 1'b0;

    // serial line capture and expected waveform
    logic cap_en = 1'b0;
    bit   line_q[$];
    bit   exp_q[$];

    always @(negedge clk) begin
        if (cap_en) line_q.push_back(uart_tx);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus_if.uart_addr = a;
        bus_if.uart_din  = d;
        bus_if.tx_wen    = 1'b1;
        tick(1);
        bus_if.tx_wen    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus_if.uart_addr = a;
        bus_if.rx_ren    = 1'b1;
        @(negedge clk);
        d = bus_if.uart_dout;
        tick(1);
        bus_if.rx_ren    = 1'b0;
    endtask

    function automatic logic [7:0] stat_model();
        return {2'b00, m_perr, m_ferr, m_ovr, 1'b1, 1'b0, (m_rxq.size() != 0)};
    endfunction

    task automatic stat_read(input string tag);
        logic [7:0] d;
        bus_read(3'h4, d);
        check(tag, {24'h0, d}, {24'h0, stat_model()});
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic exp_level(input bit v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic exp_frame(input logic [7:0] b);
        exp_level(1'b0, CPB);
        for (int i = 0; i < 8; i++) exp_level(b[i], CPB);
`ifdef UART_PARITY_EN
        exp_level(^b, CPB);
`endif
        exp_level(1'b1, CPB);
    endtask

    task automatic compare_line(input string tag);
        int nbad = 0;
        int n = (exp_q.size() > line_q.size()) ? exp_q.size() : line_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= line_q.size()) nbad++;
            else if (line_q[i] != ((i < exp_q.size()) ? exp_q[i] : 1'b1)) nbad++;
        end
        check(tag, nbad, 32'd0);
    endtask

    // drive one serial frame; the model decides push, overrun or error
    task automatic rx_send(input logic [7:0] b, input logic stop, input logic pflip);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
`ifdef UART_PARITY_EN
        uart_rx = (^b) ^ pflip;
        tick(CPB);
        if (pflip && stop) m_perr = 1'b1;
        else
`endif
        if (!stop) m_ferr = 1'b1;
        else if (m_rxq.size() < 16) m_rxq.push_back(b);
        else m_ovr = 1'b1;
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        bus_if.tx_wen    = 1'b0;
        bus_if.rx_ren    = 1'b0;
        bus_if.uart_addr = 3'h0;
        bus_if.uart_din  = 8'h00;

        // reset state
        tick(2);
        bus_if.uart_addr = 3'h4;
        #1;
        check("rst_tx_line", uart_tx, 1'b1);
        check("rst_tx_full", bus_if.tx_full, 1'b0);
        check("rst_rx_dp", bus_if.rx_data_present, 1'b0);
        check("rst_status", bus_if.uart_dout, 8'h04);
        rst = 1'b1;
        tick(2);

        // single 0x55 frame, first start bit two cycles after the write edge
        line_q.delete();
        exp_q.delete();
        exp_level(1'b1, 3);
        exp_frame(8'h55);
        cap_en = 1'b1;
        bus_write(3'h0, 8'h55);
        tick(50);
        cap_en = 1'b0;
        compare_line("tx_frame_55");
        stat_read("tx_idle_after_55");

        // 17 back-to-back writes fill the FIFO; an 18th is dropped
        line_q.delete();
        exp_q.delete();
        exp_level(1'b1, 3);
        cap_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            exp_frame(b);
            bus_if.uart_addr = 3'h0;
            bus_if.uart_din  = b;
            bus_if.tx_wen    = 1'b1;
            tick(1);
        end
        bus_if.tx_wen = 1'b0;
        check("tx_full_after_17", bus_if.tx_full, 1'b1);
        bus_write(3'h0, 8'hEE);
        tick(17 * 11 * CPB + 60);
        cap_en = 1'b0;
        compare_line("tx_stream_17");
        check("tx_full_drained", bus_if.tx_full, 1'b0);
        stat_read("tx_idle_after_17");

        // single RX frame 0xA3, unmapped offsets, empty read
        rx_send(8'hA3, 1'b1, 1'b0);
        tick(4);
        check("rx_dp_a3", bus_if.rx_data_present, 1'b1);
        bus_read(3'h2, d);
        check("rd_unmapped", d, 8'h00);
        bus_write(3'h6, 8'h5A);
        tick(3);
        stat_read("wr_unmapped_status");
        bus_read(3'h0, d);
        check("rx_data_a3", d, m_rxq.pop_front());
        check("rx_dp_after_pop", bus_if.rx_data_present, 1'b0);
        bus_read(3'h0, d);
        check("rx_empty_read", d, 8'h00);

        // 17 random frames without reads: overrun, then drain in order
        for (int i = 0; i < 17; i++) rx_send(8'($urandom), 1'b1, 1'b0);
        tick(4);
        stat_read("rx_overrun_status");
        stat_read("rx_overrun_cleared");
        for (int i = 0; i < 16; i++) begin
            bus_read(3'h0, d);
            check($sformatf("rx_drain_%0d", i), d, m_rxq.pop_front());
        end
        check("rx_dp_drained", bus_if.rx_data_present, 1'b0);

        // bad stop bit and a one-cycle glitch
        rx_send(8'($urandom), 1'b0, 1'b0);
        tick(8);
        check("rx_ferr_no_push", bus_if.rx_data_present, 1'b0);
        stat_read("rx_frame_err");
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(20);
        check("rx_glitch_no_push", bus_if.rx_data_present, 1'b0);
        stat_read("rx_glitch_status");
`ifdef UART_PARITY_EN
        rx_send(8'($urandom), 1'b1, 1'b1);
        tick(4);
        stat_read("rx_parity_err");
`endif

        // reset during a TX data bit of 0x00
        bus_write(3'h0, 8'h00);
        tick(15);
        check("tx_mid_data_low", uart_tx, 1'b0);
        rst = 1'b0;
        #2;
        check("tx_line_on_reset", uart_tx, 1'b1);
        tick(2);
        rst = 1'b1;
        line_q.delete();
        exp_q.delete();
        cap_en = 1'b1;
        tick(60);
        cap_en = 1'b0;
        compare_line("tx_quiet_after_reset");
        stat_read("status_after_reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
